// File: rtl/hazard_scoreboard_if.sv
// Forwarding bundle: in-flight destination / write-enable per stage.
// The scoreboard drives it (master), forwarding logic reads it (slave).
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 4
);
    logic [REG_ADDR_W-1:0] EXE_dst;
    logic                  EXE_wb_en;
    logic                  EXE_mem_read;
    logic [REG_ADDR_W-1:0] MEM_dst;
    logic                  MEM_wb_en;
    logic [REG_ADDR_W-1:0] WB_dst;
    logic                  WB_wb_en;

    modport master (
        output EXE_dst,
        output EXE_wb_en,
        output EXE_mem_read,
        output MEM_dst,
        output MEM_wb_en,
        output WB_dst,
        output WB_wb_en
    );

    modport slave (
        input EXE_dst,
        input EXE_wb_en,
        input EXE_mem_read,
        input MEM_dst,
        input MEM_wb_en,
        input WB_dst,
        input WB_wb_en
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight writes through EXE/MEM/WB and raises the ID stall.
// Also counts stalled cycles with a saturating counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dst,
    output logic                  hazard,
    hazard_scoreboard_if.master   fwd,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [REG_ADDR_W-1:0] exe_dst;
    logic                  exe_wb_en;
    logic                  exe_mem_read;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic                  mem_wb_en;
    logic [REG_ADDR_W-1:0] wb_dst;
    logic                  wb_wb_en;

    logic s1_exe;
    logic s1_mem;
    logic s2_exe;
    logic s2_mem;
    logic raw_hit;
    logic lu_hit;
    logic accept;

    // Source-vs-stage matches; only stages that will write count.
    assign s1_exe = exe_wb_en && (id_src1 == exe_dst);
    assign s1_mem = mem_wb_en && (id_src1 == mem_dst);
    assign s2_exe = id_two_src && exe_wb_en && (id_src2 == exe_dst);
    assign s2_mem = id_two_src && mem_wb_en && (id_src2 == mem_dst);

    // Without forwarding any EXE/MEM producer blocks; WB writes on negedge.
    assign raw_hit = s1_exe | s1_mem | s2_exe | s2_mem;

    // With forwarding only a load still in EXE cannot supply its data.
    assign lu_hit = exe_mem_read & (s1_exe | s2_exe);

    // A flushed ID instruction is dead, so it never stalls.
    assign hazard = id_valid & ~flush
                  & (forward_en ? lu_hit : raw_hit);

    assign accept = id_valid & ~hazard & ~flush;

    // Stage pipeline: advance unless memory freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_dst      <= '0;
            exe_wb_en    <= 1'b0;
            exe_mem_read <= 1'b0;
            mem_dst      <= '0;
            mem_wb_en    <= 1'b0;
            wb_dst       <= '0;
            wb_wb_en     <= 1'b0;
        end else if (!freeze) begin
            wb_dst    <= mem_dst;
            wb_wb_en  <= mem_wb_en;
            mem_dst   <= exe_dst;
            mem_wb_en <= exe_wb_en;
            if (accept) begin
                exe_dst      <= id_dst;
                exe_wb_en    <= id_wb_en;
                exe_mem_read <= id_mem_read;
            end else begin
                exe_dst      <= '0;
                exe_wb_en    <= 1'b0;
                exe_mem_read <= 1'b0;
            end
        end
    end

    // Saturating count of cycles actually spent stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (hazard && !freeze && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign fwd.EXE_dst      = exe_dst;
    assign fwd.EXE_wb_en    = exe_wb_en;
    assign fwd.EXE_mem_read = exe_mem_read;
    assign fwd.MEM_dst      = mem_dst;
    assign fwd.MEM_wb_en    = mem_wb_en;
    assign fwd.WB_dst       = wb_dst;
    assign fwd.WB_wb_en     = wb_wb_en;

endmodule
